// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
// Shared types and defaults for the reset sequencer:
//   seq_state_e   : sequencer FSM states
//   HOLD_CYC_DEF  : default clocks all domain resets are held after reset/abort
//   STAGE_DLY_DEF : default enabled ticks between consecutive domain releases
//   stage_w()     : width of a count that must reach n (0..n inclusive)
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  localparam int HOLD_CYC_DEF  = 16;
  localparam int STAGE_DLY_DEF = 1024;

  function automatic int stage_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
// Groups the sequencer's status/request inputs and per-domain reset outputs.
//   i_enb      : tick strobe, stage delay advances only when high
//   i_lock     : PLL/clock-lock status (synchronous)
//   i_soft_req : single-cycle soft-reset request
//   o_rstn     : per-domain active-low resets (stage 0 released first)
//   o_stage    : number of domains released
//   o_ready    : all domains released
//   o_err      : sticky lock-loss-after-release-began flag
// Modports:
//   master : the sequencer itself (drives the domain resets)
//   slave  : the surrounding logic (drives lock/tick/request, observes resets)
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES = 4
);
  localparam int STAGE_W = stage_w(N_STAGES);

  logic                i_enb;
  logic                i_lock;
  logic                i_soft_req;
  logic [N_STAGES-1:0] o_rstn;
  logic [STAGE_W-1:0]  o_stage;
  logic                o_ready;
  logic                o_err;

  modport master (
    input  i_enb, i_lock, i_soft_req,
    output o_rstn, o_stage, o_ready, o_err
  );

  modport slave (
    output i_enb, i_lock, i_soft_req,
    input  o_rstn, o_stage, o_ready, o_err
  );

endinterface

// File: rtl/reset_seq_timer.sv
// reset_seq_timer
// Shared up-counter for both the reset hold time and the per-stage delay.
//   i_clk  : clock
//   i_rstn : synchronous active-low reset (count to 0)
//   i_clr  : clear count to 0 (wins over i_en)
//   i_en   : advance count by one
//   i_term : terminal value to compare against
//   o_tc   : current count equals i_term
module reset_seq_timer #(
  parameter int CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = (cnt_q == i_term);

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Ordered reset-release controller. Holds every domain reset for HOLD_CYC
// clocks, waits for clock lock, then releases domains 0..N_STAGES-1 one at a
// time, each after STAGE_DLY enabled ticks. Lock loss or a soft request after
// release has begun re-asserts all domains and restarts; lock loss also sets
// the sticky error flag.
//   i_clk  : clock, rising edge
//   i_rstn : synchronous active-low reset
//   bus    : reset_sequencer_if master (lock/tick/request in, resets/status out)
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES  = 4,
  parameter int CNT_W     = 10,
  parameter int HOLD_CYC  = HOLD_CYC_DEF,
  parameter int STAGE_DLY = STAGE_DLY_DEF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  reset_sequencer_if.master bus
);

  localparam int               STAGE_W    = stage_w(N_STAGES);
  localparam logic [CNT_W-1:0] HOLD_TERM  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAGE_TERM = CNT_W'(STAGE_DLY - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STAGES - 1);

  if (N_STAGES < 1) begin : g_bad_nstages
    $error("reset_sequencer: N_STAGES must be >= 1");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > (2 ** CNT_W)) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYC must be in 1..2**CNT_W");
  end
  if (STAGE_DLY < 1 || STAGE_DLY > (2 ** CNT_W)) begin : g_bad_dly
    $error("reset_sequencer: STAGE_DLY must be in 1..2**CNT_W");
  end

  seq_state_e          state_q;
  logic [N_STAGES-1:0] rstn_q;
  logic [STAGE_W-1:0]  stage_q;
  logic                ready_q;
  logic                err_q;

  logic             abort;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_tc;
  logic [CNT_W-1:0] tmr_term;

  // Abort only applies once release has begun; lock low earlier is normal.
  assign abort = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) &&
                 (!bus.i_lock || bus.i_soft_req);

  assign tmr_term = (state_q == ST_ASSERT) ? HOLD_TERM : STAGE_TERM;

  // The one counter is parked at 0 whenever it is not timing something, so
  // each timed phase starts from a clean count.
  always_comb begin
    tmr_en  = 1'b0;
    tmr_clr = 1'b1;
    case (state_q)
      ST_ASSERT: begin
        tmr_en  = 1'b1;
        tmr_clr = bus.i_soft_req || tmr_tc;
      end
      ST_RELEASE: begin
        tmr_en  = bus.i_enb;
        tmr_clr = abort || (bus.i_enb && tmr_tc);
      end
      default: begin
        tmr_en  = 1'b0;
        tmr_clr = 1'b1;
      end
    endcase
  end

  reset_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (tmr_clr),
    .i_en   (tmr_en),
    .i_term (tmr_term),
    .o_tc   (tmr_tc)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= ST_ASSERT;
      rstn_q  <= '0;
      stage_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          // A soft request restarts the hold instead of finishing it.
          if (!bus.i_soft_req && tmr_tc) begin
            state_q <= ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          if (bus.i_lock) begin
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (abort) begin
            state_q <= ST_ASSERT;
            rstn_q  <= '0;
            stage_q <= '0;
            ready_q <= 1'b0;
            if (!bus.i_lock) begin
              err_q <= 1'b1;
            end
          end else if ((state_q == ST_RELEASE) && bus.i_enb && tmr_tc) begin
            // Setting only bit [stage_q] keeps o_rstn thermometer-shaped.
            rstn_q  <= rstn_q | (N_STAGES'(1) << stage_q);
            stage_q <= stage_q + 1'b1;
            if (stage_q == LAST_STAGE) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_ASSERT;
        end
      endcase
    end
  end

  assign bus.o_rstn  = rstn_q;
  assign bus.o_stage = stage_q;
  assign bus.o_ready = ready_q;
  assign bus.o_err   = err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Scoreboard bench for reset_sequencer (N_STAGES=3, CNT_W=4, HOLD_CYC=4,
// STAGE_DLY=5). Each clock the reference model's expected outputs are queued
// when inputs are applied and popped/compared after the edge; directed checks
// anchor the documented cycle positions.
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int CW   = 4;
  localparam int HOLD = 4;
  localparam int DLY  = 5;

  typedef struct {
    logic [2:0] rstn;
    logic [1:0] stage;
    logic       ready;
    logic       err;
  } exp_t;

  logic clk;
  logic tb_rstn;

  reset_sequencer_if #(.N_STAGES(N)) bus ();

  reset_sequencer #(
    .N_STAGES  (N),
    .CNT_W     (CW),
    .HOLD_CYC  (HOLD),
    .STAGE_DLY (DLY)
  ) dut (
    .i_clk  (clk),
    .i_rstn (tb_rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t sb_q[$];

  // Reference model state: 0=ASSERT 1=WAIT_LOCK 2=RELEASE 3=RUN
  int         m_st    = 0;
  int         m_cnt   = 0;
  logic [2:0] m_rstn  = '0;
  int         m_stage = 0;
  logic       m_ready = 1'b0;
  logic       m_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_update();
    if (!tb_rstn) begin
      m_st = 0; m_cnt = 0; m_rstn = '0; m_stage = 0; m_ready = 1'b0; m_err = 1'b0;
    end else begin
      case (m_st)
        0: begin
          if (bus.i_soft_req) m_cnt = 0;
          else if (m_cnt == HOLD - 1) begin m_st = 1; m_cnt = 0; end
          else m_cnt++;
        end
        1: begin
          if (bus.i_lock) begin m_st = 2; m_cnt = 0; end
        end
        default: begin
          if (!bus.i_lock || bus.i_soft_req) begin
            if (!bus.i_lock) m_err = 1'b1;
            m_st = 0; m_cnt = 0; m_rstn = '0; m_stage = 0; m_ready = 1'b0;
          end else if (m_st == 2 && bus.i_enb) begin
            if (m_cnt == DLY - 1) begin
              m_rstn  = {m_rstn[1:0], 1'b1};
              m_stage = m_stage + 1;
              m_cnt   = 0;
              if (m_stage == N) begin m_st = 3; m_ready = 1'b1; end
            end else begin
              m_cnt++;
            end
          end
        end
      endcase
    end
  endtask

  // Inputs are already applied; queue the model's prediction, clock, compare.
  task automatic step();
    exp_t e;
    model_update();
    e.rstn  = m_rstn;
    e.stage = 2'(m_stage);
    e.ready = m_ready;
    e.err   = m_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_rstn",  32'(bus.o_rstn),  32'(e.rstn));
    chk("sb_stage", 32'(bus.o_stage), 32'(e.stage));
    chk("sb_ready", 32'(bus.o_ready), 32'(e.ready));
    chk("sb_err",   32'(bus.o_err),   32'(e.err));
  endtask

  initial begin
    int prev_stage;
    int last_rel;
    logic enb_at_edge;

    tb_rstn = 1'b0;
    bus.i_enb = 1'b0;
    bus.i_lock = 1'b0;
    bus.i_soft_req = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_rstn",  32'(bus.o_rstn),  32'd0);
    chk("rst_stage", 32'(bus.o_stage), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd0);
    chk("rst_err",   32'(bus.o_err),   32'd0);

    // Nominal sequence
    tb_rstn = 1'b1; bus.i_lock = 1'b1; bus.i_enb = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      step();
      if (e == 4)  chk("nom_hold", 32'(bus.o_rstn), 32'b000);
      if (e == 9)  chk("nom_pre0", 32'(bus.o_rstn), 32'b000);
      if (e == 10) chk("nom_s0",   32'(bus.o_rstn), 32'b001);
      if (e == 14) chk("nom_pre1", 32'(bus.o_rstn), 32'b001);
      if (e == 15) chk("nom_s1",   32'(bus.o_rstn), 32'b011);
      if (e == 19) chk("nom_rdy19", 32'(bus.o_ready), 32'd0);
      if (e == 20) begin
        chk("nom_s2",    32'(bus.o_rstn),  32'b111);
        chk("nom_rdy",   32'(bus.o_ready), 32'd1);
        chk("nom_stage", 32'(bus.o_stage), 32'd3);
      end
    end

    // Lock loss in RUN, then full repeat with sticky error
    bus.i_lock = 1'b0;
    step();
    chk("lol_rstn",  32'(bus.o_rstn),  32'd0);
    chk("lol_ready", 32'(bus.o_ready), 32'd0);
    chk("lol_err",   32'(bus.o_err),   32'd1);
    bus.i_lock = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 19) chk("lol_rdy19", 32'(bus.o_ready), 32'd0);
      if (e == 20) begin
        chk("lol_rdy20", 32'(bus.o_rstn), 32'b111);
        chk("lol_sticky", 32'(bus.o_err), 32'd1);
      end
    end

    // Gated ticks: i_enb every third clock
    tb_rstn = 1'b0; step(); tb_rstn = 1'b1;
    prev_stage = 0;
    last_rel = 0;
    for (int e = 1; e <= 90; e++) begin
      bus.i_enb = ((e % 3) == 0);
      enb_at_edge = bus.i_enb;
      step();
      if (int'(bus.o_stage) != prev_stage) begin
        chk("gate_inc", 32'(bus.o_stage), 32'(prev_stage + 1));
        chk("gate_enb", 32'(enb_at_edge), 32'd1);
        if (prev_stage > 0) chk("gate_gap", 32'(e - last_rel), 32'd15);
        last_rel = e;
        prev_stage = int'(bus.o_stage);
      end
    end
    chk("gate_final", 32'(bus.o_stage), 32'd3);
    bus.i_enb = 1'b1;

    // Soft request on the edge that would release stage 1
    tb_rstn = 1'b0; step(); tb_rstn = 1'b1;
    for (int e = 1; e <= 14; e++) step();
    chk("col_pre", 32'(bus.o_stage), 32'd1);
    bus.i_soft_req = 1'b1;
    step();
    bus.i_soft_req = 1'b0;
    chk("col_rstn",  32'(bus.o_rstn),  32'd0);
    chk("col_stage", 32'(bus.o_stage), 32'd0);
    chk("col_err",   32'(bus.o_err),   32'd0);
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 9)  chk("col_hold", 32'(bus.o_rstn), 32'b000);
      if (e == 10) chk("col_s0",   32'(bus.o_rstn), 32'b001);
    end

    // Soft request in ASSERT at hold count 2
    tb_rstn = 1'b0; step(); tb_rstn = 1'b1;
    step(); step();
    bus.i_soft_req = 1'b1;
    step();
    bus.i_soft_req = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 9)  chk("sa_hold", 32'(bus.o_rstn), 32'b000);
      if (e == 10) chk("sa_s0",   32'(bus.o_rstn), 32'b001);
    end

    // Error mid-RELEASE, then i_rstn low clears everything
    bus.i_lock = 1'b0;
    step();
    chk("mr_err", 32'(bus.o_err), 32'd1);
    bus.i_lock = 1'b1;
    for (int e = 1; e <= 10; e++) step();
    chk("mr_pre", 32'(bus.o_stage), 32'd1);
    tb_rstn = 1'b0;
    step();
    chk("mr_rstn",  32'(bus.o_rstn),  32'd0);
    chk("mr_stage", 32'(bus.o_stage), 32'd0);
    chk("mr_ready", 32'(bus.o_ready), 32'd0);
    chk("mr_err0",  32'(bus.o_err),   32'd0);

    // Lock low in WAIT_LOCK for a long time (soft request there is ignored)
    tb_rstn = 1'b1; bus.i_lock = 1'b0;
    for (int e = 1; e <= 54; e++) begin
      bus.i_soft_req = (e == 20);
      step();
    end
    bus.i_soft_req = 1'b0;
    chk("wl_rstn", 32'(bus.o_rstn), 32'd0);
    chk("wl_err",  32'(bus.o_err),  32'd0);
    bus.i_lock = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 5) chk("wl_pre", 32'(bus.o_rstn), 32'b000);
      if (e == 6) chk("wl_s0",  32'(bus.o_rstn), 32'b001);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      tb_rstn        = ($urandom_range(0, 199) != 0);
      bus.i_lock     = ($urandom_range(0, 39) != 0);
      bus.i_soft_req = ($urandom_range(0, 49) == 0);
      bus.i_enb      = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
